ofdm_bit_interleaver: RTL
=========================

// Module: ofdm_bit_interleaver
// PURPOSE
//  Parametrised 802.11a per-symbol block interleaver (both permutation steps) for all
//  four modulations: BPSK/QPSK/16-QAM/64-QAM, N_CBPS = 48/96/192/288.
//  Sits in the transmitter between the puncturer/convolutional encoder and the mapper.
//  Ping-pong bit memory gives 1 bit/clock sustained, with valid/ready on both sides.
// PARAMETERS
//  MAX_N_BPSC  6    largest supported bits/subcarrier (1,2,4,6); sizes each bank to 48*MAX_N_BPSC bits
//  IDX_W       9    bit-index width, >= clog2(48*MAX_N_BPSC)
// PORTS
//  Clock     in   1      rising-edge clock
//  Reset     in   1      asynchronous, active-high
//  Mode      in   2      0=BPSK(N_BPSC 1), 1=QPSK(2), 2=16QAM(4), 3=64QAM(6); sampled per symbol
//  InValid   in   1      InData valid
//  InData    in   1      coded bit, input order k
//  InReady   out  1      block accepts InData this cycle
//  OutValid  out  1      OutData valid
//  OutData   out  1      interleaved bit, output order j
//  OutReady  in   1      downstream accepts OutData
//  OutLast   out  1      qualifies last bit of symbol (OutValid && index == N_CBPS-1)
//  ModeErr   out  1      one-cycle pulse: unsupported Mode latched
// BEHAVIOUR
//  - Reset: InReady=0 while Reset high, 1 the first cycle after release. OutValid=0, OutData=0,
//    OutLast=0, ModeErr=0. Both banks empty, write/read bank select=0, indices=0.
//    Bank contents are not cleared.
//  - Accept on InValid&&InReady; emit on OutValid&&OutReady.
//  - Mode latches into write-bank descriptor on accepted bit with wr_idx==0.
//    Mode changes mid-symbol are ignored.
//    If N_BPSC(Mode) > MAX_N_BPSC: treat as BPSK and pulse ModeErr on the cycle after acceptance.
//  - N_CBPS=48*N_BPSC, s=max(N_BPSC/2,1). Accepted bit k is written to address j:
//    i = (N_CBPS/16)*(k mod 16) + floor(k/16)
//    j = s*floor(i/s) + (i + N_CBPS - floor(16*i/N_CBPS)) mod s
//    Compute combinationally or via a per-mode counter; no multipliers needed by the spec.
//  - Write side: InReady = !full[wr_sel].
//    On accepting k==N_CBPS-1: set full[wr_sel], toggle wr_sel, wr_idx<=0.
//  - Read side: OutValid = full[rd_sel]; OutData = bank[rd_sel][rd_idx]; N_CBPS taken from bank descriptor.
//    On emit: rd_idx++. On emit of the last bit: clear full[rd_sel], toggle rd_sel, rd_idx<=0.
//  - Latency: last input bit of a symbol accepted at edge t -> OutValid=1 (out index 0) after edge t.
//  - Throughput: with OutReady held at 1, symbols stream back-to-back with no idle cycle
//    on either side.
//  - OutData/OutLast are stable while OutValid && !OutReady.
//  - Simultaneous events:
//    last write into bank A and last read of bank B in the same cycle are independent and both take effect;
//    reader and writer never address the same bank.
//  - Both banks full: InReady=0 until the read bank's last bit is emitted.
//    InReady returns to 1 the cycle after that emit.
//  - Reset mid-symbol: partial input and undelivered output are discarded; no OutValid until a full
//    new symbol is received.
// TESTING
//  - BPSK, 48 bits, only k=16 set, OutReady=1 -> single 1 at out index 1; OutLast at index 47.
//  - QPSK, only k=1 set -> 1 at out index 6.
//  - 16QAM, only k=1 set -> 1 at out index 13.
//  - 64QAM, only k=1 set -> 1 at out index 20; k=0 -> index 0.
//  - Random bits, all 4 modes interleaved back-to-back, OutReady=1 -> matches golden model;
//    zero idle cycles; OutValid rises 1 cycle after each symbol's last input.
//  - OutReady=0, push 3 BPSK symbols -> InReady drops after bit 95 and stays 0 for symbol 3.
//    After OutReady=1, InReady=1 the cycle after out index 47 of symbol 1 is emitted.
//  - Reset at k=100 of 64QAM -> all outputs 0 at once.
//    Next BPSK symbol is then interleaved correctly.
//  - MAX_N_BPSC=2, Mode=3 -> ModeErr pulse; symbol treated as BPSK (48 bits).

Source files
------------

// File: rtl/ofdm_bit_interleaver.sv
// 802.11a per-symbol bit interleaver (both permutation steps) for BPSK, QPSK, 16QAM and 64QAM.
// Two symbol banks alternate so one symbol can be written while the previous one is read.
module ofdm_bit_interleaver #(
  parameter int MAX_N_BPSC = 6,
  parameter int IDX_W      = 9
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic [1:0] Mode,
  input  logic       InValid,
  input  logic       InData,
  output logic       InReady,
  output logic       OutValid,
  output logic       OutData,
  input  logic       OutReady,
  output logic       OutLast,
  output logic       ModeErr
);

  localparam int BANK_BITS = 48 * MAX_N_BPSC;
  localparam int AW        = $clog2(BANK_BITS);

  logic [BANK_BITS-1:0] bank [2];
  logic [1:0]           desc [2];
  logic [1:0]           full;
  logic                 wr_sel;
  logic                 rd_sel;
  logic [IDX_W-1:0]     wr_idx;
  logic [IDX_W-1:0]     rd_idx;
  logic                 mode_err;

  logic [1:0]           mode_eff;
  logic [1:0]           wr_mode;
  logic                 accept;
  logic                 emit;
  logic                 wr_last;
  logic                 rd_last;
  logic [IDX_W-1:0]     wr_addr;
  logic [IDX_W-1:0]     k_lo;
  logic [IDX_W-1:0]     k_hi;
  logic [IDX_W-1:0]     row_i;
  logic [IDX_W-1:0]     q_mod;
  logic [IDX_W-1:0]     m_mod;

  function automatic logic [IDX_W-1:0] n_cbps(input logic [1:0] m);
    case (m)
      2'd0:    n_cbps = IDX_W'(48);
      2'd1:    n_cbps = IDX_W'(96);
      2'd2:    n_cbps = IDX_W'(192);
      default: n_cbps = IDX_W'(288);
    endcase
  endfunction

  function automatic logic mode_ok(input logic [1:0] m);
    case (m)
      2'd0:    mode_ok = 1'b1;
      2'd1:    mode_ok = (MAX_N_BPSC >= 2);
      2'd2:    mode_ok = (MAX_N_BPSC >= 4);
      default: mode_ok = (MAX_N_BPSC >= 6);
    endcase
  endfunction

  // Mode is only looked at on the first bit of a symbol; afterwards the bank descriptor rules.
  assign mode_eff = mode_ok(Mode) ? Mode : 2'd0;
  assign wr_mode  = (wr_idx == '0) ? mode_eff : desc[wr_sel];
  assign InReady  = !Reset && !full[wr_sel];
  assign accept   = InValid && InReady;
  assign wr_last  = (wr_idx == n_cbps(wr_mode) - IDX_W'(1));

  assign OutValid = full[rd_sel];
  assign OutData  = full[rd_sel] && bank[rd_sel][rd_idx[AW-1:0]];
  assign rd_last  = (rd_idx == n_cbps(desc[rd_sel]) - IDX_W'(1));
  assign OutLast  = OutValid && rd_last;
  assign emit     = OutValid && OutReady;
  assign ModeErr  = mode_err;

  // Since k/16 never reaches N_CBPS/16, floor(16*i/N_CBPS) is just k mod 16, which
  // reduces the second permutation to a parity flip (s=2) or a mod-3 rotation (s=3).
  always_comb begin
    k_lo    = IDX_W'(wr_idx[3:0]);
    k_hi    = wr_idx >> 4;
    row_i   = '0;
    q_mod   = '0;
    m_mod   = '0;
    wr_addr = '0;
    case (wr_mode)
      2'd0: begin
        row_i   = IDX_W'(3) * k_lo + k_hi;
        wr_addr = row_i;
      end
      2'd1: begin
        row_i   = IDX_W'(6) * k_lo + k_hi;
        wr_addr = row_i;
      end
      2'd2: begin
        row_i   = IDX_W'(12) * k_lo + k_hi;
        wr_addr = {row_i[IDX_W-1:1], row_i[0] ^ wr_idx[0]};
      end
      default: begin
        row_i   = IDX_W'(18) * k_lo + k_hi;
        q_mod   = k_hi % IDX_W'(3);
        m_mod   = k_lo % IDX_W'(3);
        wr_addr = row_i - q_mod + ((q_mod + IDX_W'(3) - m_mod) % IDX_W'(3));
      end
    endcase
  end

  // Writer and reader always own different banks, so their full-flag updates never collide.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      full     <= '0;
      wr_sel   <= 1'b0;
      rd_sel   <= 1'b0;
      wr_idx   <= '0;
      rd_idx   <= '0;
      mode_err <= 1'b0;
      desc[0]  <= 2'd0;
      desc[1]  <= 2'd0;
    end else begin
      mode_err <= accept && (wr_idx == '0) && !mode_ok(Mode);
      if (accept) begin
        if (wr_idx == '0) begin
          desc[wr_sel] <= mode_eff;
        end
        if (wr_last) begin
          full[wr_sel] <= 1'b1;
          wr_sel       <= !wr_sel;
          wr_idx       <= '0;
        end else begin
          wr_idx <= wr_idx + IDX_W'(1);
        end
      end
      if (emit) begin
        if (rd_last) begin
          full[rd_sel] <= 1'b0;
          rd_sel       <= !rd_sel;
          rd_idx       <= '0;
        end else begin
          rd_idx <= rd_idx + IDX_W'(1);
        end
      end
    end
  end

  // Bit storage is deliberately left out of reset; the full flags gate everything read from it.
  always_ff @(posedge Clock) begin
    if (accept) begin
      bank[wr_sel][wr_addr[AW-1:0]] <= InData;
    end
  end

endmodule
